// File: rtl/mac_accum_nbit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_accum_nbit_if
//  Purpose  : Operand-stream, job-control and result handshake bundle for
//             the multiply-accumulate stage.
//  Revision : 1.0 - initial release
// ============================================================================
interface mac_accum_nbit_if #(
  parameter int WIDTH     = 32,
  parameter int LEN_WIDTH = 8
);
  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_acc;
  logic                 out_wrap;
  logic                 busy;

  // Producer / consumer side (operand fetch and result sink)
  modport master (
    output start, len, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_acc, out_wrap, busy
  );

  // Accumulator side
  modport slave (
    input  start, len, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_acc, out_wrap, busy
  );
endinterface
`default_nettype wire

// File: rtl/mac_accum_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : mac_accum_nbit
//  Purpose  : Sequential multiply-accumulate stage. Registers each operand
//             pair, multiplies it with multiplier_nbit, accumulates the
//             truncated products and returns the sum through valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_accum_nbit #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0,
  parameter int LEN_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mac_accum_nbit_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           r_state;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic                 r_v;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_acc;
  logic                 r_wrap;

  logic                 w_hs;
  logic                 w_start;
  logic [WIDTH-1:0]     w_prod;
  logic [WIDTH:0]       w_sum;

  // A pair is consumed only while collecting operands
  assign w_hs    = bus.in_valid && (r_state == S_ACCUM);
  // start is honoured only when no job is in flight
  assign w_start = bus.start && (r_state == S_IDLE);

  multiplier_nbit #(
    .WIDTH     (WIDTH),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_mul (
    .a (r_a),
    .b (r_b),
    .p (w_prod)
  );

  // Extra top bit captures the carry out of the accumulator
  assign w_sum = {1'b0, r_acc} + {1'b0, w_prod};

  // Job control: count accepted pairs, then drain the last product
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.len != '0) begin
              r_remaining <= bus.len;
              r_state     <= S_ACCUM;
            end else begin
              r_state     <= S_DONE;
            end
          end
        end
        S_ACCUM: begin
          if (w_hs) begin
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == LEN_WIDTH'(1)) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: r_state <= S_DONE;
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand stage register feeding the combinational multiplier
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v <= 1'b0;
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_v <= w_hs;
      if (w_hs) begin
        r_a <= bus.in_a;
        r_b <= bus.in_b;
      end
    end
  end

  // Accumulator: cleared on a new job, adds the staged product when valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (w_start) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (r_v) begin
      r_acc  <= w_sum[WIDTH-1:0];
      r_wrap <= r_wrap | w_sum[WIDTH];
    end
  end

  assign bus.in_ready  = (r_state == S_ACCUM);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_acc   = r_acc;
  assign bus.out_wrap  = r_wrap;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// ============================================================================
//  Module   : multiplier_nbit
//  Purpose  : Combinational WIDTH x WIDTH multiplier returning the low WIDTH
//             bits of the product. IMPL_TYPE selects the adder structure.
//  Revision : 1.0 - initial release
// ============================================================================
module multiplier_nbit #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);

  generate
    if (IMPL_TYPE == 0) begin : g_direct
      // Let synthesis pick the multiplier architecture
      assign p = a * b;
    end else begin : g_shift_add
      // Explicit shift-and-add array of partial products
      always_comb begin
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (b[i]) begin
            p = p + (a << i);
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mac_accum_nbit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mac_accum_nbit
//  Purpose  : Self-checking bench for mac_accum_nbit (WIDTH=8) with an
//             arithmetic reference model and a per-cycle output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_accum_nbit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mac_accum_nbit_if #(.WIDTH(8), .LEN_WIDTH(8)) bus ();

  mac_accum_nbit #(
    .WIDTH     (8),
    .IMPL_TYPE (0),
    .LEN_WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  int         ja [0:15];
  int         jb [0:15];
  logic [7:0] exp_acc  = '0;
  logic       exp_wrap = 1'b0;
  bit         mon_en   = 1'b0;
  bit         expect_idle = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Dot product of the first n pairs, mod 256, with sticky carry
  function automatic void model(input int n, output logic [7:0] acc, output logic wrap);
    int s;
    acc  = '0;
    wrap = 1'b0;
    for (int i = 0; i < n; i++) begin
      s    = int'(acc) + ((ja[i] * jb[i]) % 256);
      wrap = wrap | (s > 255);
      acc  = s[7:0];
    end
  endfunction

  // Monitor: result content whenever valid, and valid never drops unaccepted
  bit h_prev = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (h_prev) chk("mon_valid_held", bus.out_valid, 1);
      if (expect_idle) begin
        chk("mon_no_valid_after_reset", bus.out_valid, 0);
      end else if (bus.out_valid) begin
        chk("mon_acc", bus.out_acc, exp_acc);
        chk("mon_wrap", bus.out_wrap, exp_wrap);
      end
    end
    h_prev = mon_en && bus.out_valid && !bus.out_ready;
  end

  task automatic run_job(input int n, input int gap_pct, input int hold, input bit pulse_start,
                         output logic [7:0] racc, output logic rwrap);
    int k;
    int cyc;
    int w;
    bit hs;
    @(negedge clk);
    model(n, exp_acc, exp_wrap);
    bus.out_ready = (hold == 0);
    bus.start     = 1'b1;
    bus.len       = 8'(n);
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = 8'($urandom);
    chk("busy_after_start", bus.busy, 1);
    if (n == 0) chk("len0_valid_latency", bus.out_valid, 1);
    else        chk("in_ready_after_start", bus.in_ready, 1);
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 2000) begin
      if ($urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_a     = 8'($urandom);
        bus.in_b     = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_a     = 8'(ja[k]);
        bus.in_b     = 8'(jb[k]);
      end
      if (pulse_start) bus.start = 1'($urandom_range(1));
      hs = bus.in_valid && bus.in_ready;
      @(negedge clk);
      cyc++;
      if (hs) k++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (k < n) chk("feed_timeout", k, n);
    if (n != 0) begin
      chk("drain_no_valid", bus.out_valid, 0);
      chk("drain_in_ready", bus.in_ready, 0);
      w = 0;
      while (!bus.out_valid && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("out_valid_latency", w, 1);
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("valid_held_until_ready", bus.out_valid, 1);
    end
    racc  = bus.out_acc;
    rwrap = bus.out_wrap;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("busy_after_handshake", bus.busy, 0);
    chk("valid_after_handshake", bus.out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] racc;
    logic       rwrap;
    int         n;

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_acc", bus.out_acc, 0);
    chk("reset_out_wrap", bus.out_wrap, 0);
    chk("reset_busy", bus.busy, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Back-to-back basic dot product
    ja[0] = 3; jb[0] = 4; ja[1] = 5; jb[1] = 6; ja[2] = 7; jb[2] = 2;
    run_job(3, 0, 0, 1'b0, racc, rwrap);
    chk("t1_acc", racc, 56);
    chk("t1_wrap", rwrap, 0);

    // Product truncation without accumulate carry
    ja[0] = 16; jb[0] = 16; ja[1] = 15; jb[1] = 17;
    run_job(2, 0, 0, 1'b0, racc, rwrap);
    chk("t2_acc", racc, 255);
    chk("t2_wrap", rwrap, 0);

    // Accumulate carry, then a fresh job clears the flag
    ja[0] = 200; jb[0] = 1; ja[1] = 100; jb[1] = 1;
    run_job(2, 0, 1, 1'b0, racc, rwrap);
    chk("t3_acc", racc, 44);
    chk("t3_wrap", rwrap, 1);
    ja[0] = 1; jb[0] = 1;
    run_job(1, 0, 0, 1'b0, racc, rwrap);
    chk("t3b_acc", racc, 1);
    chk("t3b_wrap", rwrap, 0);

    // Empty job with a stalled consumer
    run_job(0, 0, 5, 1'b0, racc, rwrap);
    chk("t4_acc", racc, 0);
    chk("t4_wrap", rwrap, 0);

    // Input gaps and ignored mid-job start pulses
    ja[0] = 1; jb[0] = 2; ja[1] = 3; jb[1] = 4; ja[2] = 5; jb[2] = 6; ja[3] = 7; jb[3] = 8;
    run_job(4, 40, 2, 1'b1, racc, rwrap);
    chk("t5_acc", racc, 100);
    chk("t5_wrap", rwrap, 0);

    // Reset after two handshakes discards the job
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 8'd4;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd10;
    bus.in_b     = 8'd10;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    expect_idle  = 1'b1;
    @(negedge clk);
    chk("midreset_in_ready", bus.in_ready, 0);
    chk("midreset_out_valid", bus.out_valid, 0);
    chk("midreset_out_acc", bus.out_acc, 0);
    chk("midreset_out_wrap", bus.out_wrap, 0);
    chk("midreset_busy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midreset_still_idle", bus.busy, 0);
    expect_idle = 1'b0;
    ja[0] = 9; jb[0] = 9;
    run_job(1, 0, 0, 1'b0, racc, rwrap);
    chk("t6_acc", racc, 81);
    chk("t6_wrap", rwrap, 0);

    // Randomized jobs against the arithmetic model
    for (int j = 0; j < 25; j++) begin
      n = int'($urandom_range(1, 10));
      for (int i = 0; i < n; i++) begin
        ja[i] = int'($urandom_range(255));
        jb[i] = int'($urandom_range(255));
      end
      run_job(n, int'($urandom_range(50)), int'($urandom_range(3)),
              1'($urandom_range(1)), racc, rwrap);
      chk("rand_acc", racc, exp_acc);
      chk("rand_wrap", rwrap, exp_wrap);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
